program_loader: RTL and testbench

//   Boot-time loader upstream of the CPU instruction memory. Receives a byte

---
 rtl/program_loader_if.sv | 30 +++
 rtl/program_loader.sv | 121 ++++++++++++
 tb/tb_program_loader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream in, instruction memory write port out
//
// Purpose: groups the loader's inbound byte stream handshake and its
// instruction memory write port.
// Signals:
//   in_valid        stream byte valid (source -> loader)
//   in_byte         stream byte, 8 bits (source -> loader)
//   in_ready        loader accepts a byte this cycle (loader -> source)
//   im_write_enable one-cycle instruction memory write strobe (loader -> memory)
//   im_address      word-aligned byte address of the write, 32 bits
//   im_write_data   instruction word, 32 bits
// Modports: master = stream source / memory side, slave = loader side.
interface program_loader_if;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        im_write_enable;
    logic [31:0] im_address;
    logic [31:0] im_write_data;

    modport master (
        output in_valid, in_byte,
        input  in_ready, im_write_enable, im_address, im_write_data
    );

    modport slave (
        input  in_valid, in_byte,
        output in_ready, im_write_enable, im_address, im_write_data
    );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader packing a byte stream into instruction memory
//
// Purpose: receives a frame of a 16-bit word count N followed by N big-endian
// 32-bit words, writes each word to consecutive word addresses of the
// instruction memory and holds the CPU in reset until the load completes.
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   bus       slave modport of program_loader_if (byte stream + memory write)
//   cpu_hold  out  1 = keep CPU in reset, 0 = CPU may run
//   done      out  load completed (sticky until reset)
//   error     out  word count exceeded memory depth (sticky until reset)
module program_loader #(
    parameter int INSTR_MEM_SIZE = 32
) (
    input  logic             clock,
    input  logic             reset,
    program_loader_if.slave  bus,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {
        COUNT_HI,
        COUNT_LO,
        WORD,
        WRITE,
        DONE,
        ERROR
    } state_t;

    localparam logic [15:0] MEM_WORDS = 16'(INSTR_MEM_SIZE);

    state_t      state;
    logic [15:0] count;
    logic [15:0] index;
    logic [1:0]  byte_cnt;
    logic [23:0] partial;      // first three bytes of the word being assembled
    logic        accept;
    logic [15:0] count_full;

    // Ready is combinational so the source sees it the very cycle the FSM
    // returns to an accepting state; reset forces it low.
    assign bus.in_ready = ~reset &
                          ((state == COUNT_HI) || (state == COUNT_LO) || (state == WORD));
    assign accept       = bus.in_valid & bus.in_ready;
    assign count_full   = {count[15:8], bus.in_byte};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= COUNT_HI;
            count               <= '0;
            index               <= '0;
            byte_cnt            <= '0;
            partial             <= '0;
            bus.im_write_enable <= 1'b0;
            bus.im_address      <= '0;
            bus.im_write_data   <= '0;
            cpu_hold            <= 1'b1;
            done                <= 1'b0;
            error               <= 1'b0;
        end else begin
            bus.im_write_enable <= 1'b0;
            case (state)
                COUNT_HI: begin
                    if (accept) begin
                        count[15:8] <= bus.in_byte;
                        state       <= COUNT_LO;
                    end
                end
                COUNT_LO: begin
                    if (accept) begin
                        count[7:0] <= bus.in_byte;
                        index      <= '0;
                        byte_cnt   <= '0;
                        if (count_full == 16'd0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (count_full > MEM_WORDS) begin
                            state <= ERROR;
                            error <= 1'b1;
                        end else begin
                            state <= WORD;
                        end
                    end
                end
                WORD: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Fourth byte completes the word; strobe next cycle.
                            bus.im_write_enable <= 1'b1;
                            bus.im_address      <= {14'd0, index, 2'b00};
                            bus.im_write_data   <= {partial, bus.in_byte};
                            state               <= WRITE;
                        end else begin
                            partial <= {partial[15:0], bus.in_byte};
                        end
                    end
                end
                WRITE: begin
                    index <= index + 16'd1;
                    if (index == count - 16'd1) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state <= WORD;
                    end
                end
                DONE, ERROR: begin
                    // Terminal until reset.
                end
                default: state <= COUNT_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader
module tb_program_loader;

    logic clock;
    logic reset;
    logic cpu_hold;
    logic done;
    logic error;

    program_loader_if bus();

    program_loader #(.INSTR_MEM_SIZE(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus.slave),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int strobes = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] words[32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (!reset && bus.im_write_enable) begin
            strobes++;
            if (exp_addr.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                check("strobe_addr", bus.im_address, exp_addr.pop_front());
                check("strobe_data", bus.im_write_data, exp_data.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_byte = 8'h00;
        repeat (2) @(negedge clock);
        exp_addr.delete();
        exp_data.delete();
        strobes = 0;
        reset = 1'b0;
    endtask

    // Presents one byte after an optional idle gap and returns 1 time unit
    // after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        for (int i = 0; i < gap; i++) begin
            @(negedge clock);
            bus.in_valid = 1'b0;
        end
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_byte = b;
        waited = 0;
        while (!bus.in_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic run_frame(input int n, input int maxgap);
        send_byte(8'(n >> 8), $urandom_range(maxgap));
        send_byte(8'(n), $urandom_range(maxgap));
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(32'(4 * i));
            exp_data.push_back(words[i]);
            for (int k = 3; k >= 0; k--)
                send_byte(words[i][8*k +: 8], $urandom_range(maxgap));
            @(negedge clock);
            check("strobe_latency", 32'(bus.im_write_enable), 32'd1);
        end
        @(negedge clock);
        check("done", 32'(done), 32'd1);
        check("cpu_hold", 32'(cpu_hold), 32'd0);
        check("error_clear", 32'(error), 32'd0);
        check("ready_after_done", 32'(bus.in_ready), 32'd0);
        check("strobe_count", 32'(strobes), 32'(n));
        check("pending_writes", 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_we"}, 32'(bus.im_write_enable), 32'd0);
        check({tag, "_addr"}, bus.im_address, 32'd0);
        check({tag, "_data"}, bus.im_write_data, 32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_byte = 8'h00;
        repeat (2) @(negedge clock);
        check_reset_values("reset");

        // Two-word program, back-to-back bytes.
        do_reset();
        words[0] = 32'h8C090000;
        words[1] = 32'hAE520010;
        run_frame(2, 0);
        check("addr_hold", bus.im_address, 32'd4);

        // Same program with random idle gaps.
        do_reset();
        run_frame(2, 3);

        // Empty program.
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clock);
        check("n0_done", 32'(done), 32'd1);
        check("n0_cpu_hold", 32'(cpu_hold), 32'd0);
        repeat (2) @(negedge clock);
        check("n0_strobes", 32'(strobes), 32'd0);

        // Oversized count.
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h21, 0);
        @(negedge clock);
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_cpu_hold", 32'(cpu_hold), 32'd1);
        check("ovf_in_ready", 32'(bus.in_ready), 32'd0);
        check("ovf_done", 32'(done), 32'd0);
        bus.in_valid = 1'b1;
        repeat (4) @(negedge clock);
        bus.in_valid = 1'b0;
        check("ovf_strobes", 32'(strobes), 32'd0);

        // Full memory.
        do_reset();
        for (int i = 0; i < 32; i++) words[i] = $urandom;
        run_frame(32, 1);
        check("full_last_addr", bus.im_address, 32'h7C);

        // Reset after six bytes, then a full reload.
        do_reset();
        words[0] = 32'h8C090000;
        words[1] = 32'hAE520010;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h8C, 0);
        send_byte(8'h09, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        reset = 1'b1;
        #1;
        check_reset_values("midload");
        @(negedge clock);
        reset = 1'b0;
        check("midload_strobes", 32'(strobes), 32'd0);
        run_frame(2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
